// File: rtl/qsys_key_debounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : qsys_key_debounce_ctrl
//  Purpose  : Avalon-MM slave for the board push-buttons (active-low keys).
//             Each key is synchronised, debounced and its press edges are
//             captured in a sticky register that can raise a maskable,
//             level-sensitive interrupt.
//  Ports    : clk         - system clock (sole domain)
//             reset_n     - synchronous active-low reset
//             address     - Avalon word address (0 data, 1 rsvd, 2 mask,
//                           3 edge capture)
//             chipselect  - Avalon slave select
//             write_n     - Avalon write strobe, active-low
//             writedata   - Avalon write data
//             readdata    - Avalon read data, registered (1-cycle latency)
//             in_port     - raw asynchronous key pins
//             irq         - interrupt request, active-high level
//  Revision : 1.0 - initial release
// ============================================================================
module qsys_key_debounce_ctrl #(
  parameter int   WIDTH           = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 16,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       ADDR_DATA = 2'd0;
  localparam logic [1:0]       ADDR_MASK = 2'd2;
  localparam logic [1:0]       ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;
  logic [31:0]      rd_mux;

  // Upper write-data bits carry no register state.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:WIDTH];

  assign wr_en = chipselect & ~write_n;

  // A bit is accepted on the cycle its counter has already seen
  // DEBOUNCE_CYCLES-1 disagreeing cycles and the disagreement persists.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // A press is an accepted change while the debounced level is still high.
  assign press = accept & db;

  assign w1c = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = db;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecap;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1    <= {WIDTH{RESET_LEVEL}};
      sync2    <= {WIDTH{RESET_LEVEL}};
      db       <= {WIDTH{RESET_LEVEL}};
      edgecap  <= '0;
      irqmask  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;

      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == db[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      db <= db ^ accept;

      // Set has priority over a same-cycle software clear.
      edgecap <= (edgecap & ~w1c) | press;

      if (wr_en && address == ADDR_MASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end

      readdata <= rd_mux;
      irq      <= |(edgecap & irqmask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qsys_key_debounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qsys_key_debounce_ctrl
//  Purpose  : Directed self-checking bench for qsys_key_debounce_ctrl with
//             DEBOUNCE_CYCLES=8, WIDTH=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qsys_key_debounce_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  in_port;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  qsys_key_debounce_ctrl #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (16),
    .RESET_LEVEL     (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag,
                          input logic [31:0] exp);
    address = a;
    tick();
    check_val(tag, readdata, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 2'b11;
    #1;
    tick(2);
    check_val("rst_readdata", readdata, 32'h0);
    check_val("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;

    // Register map after reset.
    bus_read(2'd0, "rst_data", 32'h3);
    bus_read(2'd1, "rst_rsvd", 32'h0);
    bus_read(2'd2, "rst_mask", 32'h0);
    bus_read(2'd3, "rst_edge", 32'h0);
    check_val("rst_irq2", {31'd0, irq}, 32'h0);

    // Press key 0 before edge 0; db changes on edge 9, so the data read
    // (one cycle behind) shows it first after edge 10.
    address = 2'd0;
    in_port = 2'b10;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k >= 8) check_val($sformatf("lat_data_e%0d", k), readdata,
                            (k <= 9) ? 32'h3 : 32'h2);
    end
    bus_read(2'd3, "press0_edge", 32'h1);
    check_val("press0_irq_masked", {31'd0, irq}, 32'h0);

    // Clear capture, release key 0 (no capture on release), then unmask.
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, "w1c_edge", 32'h0);
    in_port = 2'b11;
    tick(10);
    bus_read(2'd0, "release0_data", 32'h3);
    bus_read(2'd3, "release0_edge", 32'h0);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, "mask_rd", 32'h1);

    // Press key 0 with mask set: edgecap on edge 9, irq on edge 10.
    in_port = 2'b10;
    tick(10);
    check_val("irq_pre", {31'd0, irq}, 32'h0);
    tick();
    check_val("irq_rise", {31'd0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check_val("irq_hold_w1c", {31'd0, irq}, 32'h1);
    tick();
    check_val("irq_fall", {31'd0, irq}, 32'h0);

    // Key 1 bounce: low 5, high 1, low 5 -> rejected.
    address = 2'd0;
    in_port = 2'b00;
    tick(5);
    in_port = 2'b10;
    tick();
    in_port = 2'b00;
    tick(5);
    check_val("bounce_data", readdata, 32'h2);
    tick(8);
    check_val("bounce_hold_data", readdata, 32'h0);
    bus_read(2'd3, "key1_edge", 32'h2);
    check_val("key1_irq_masked", {31'd0, irq}, 32'h0);

    // Release both keys: level returns after 9 edges, capture unchanged.
    address = 2'd0;
    in_port = 2'b11;
    tick(10);
    check_val("rel_before", readdata, 32'h0);
    tick();
    check_val("rel_after", readdata, 32'h3);
    bus_read(2'd3, "rel_edge", 32'h2);
    check_val("rel_irq", {31'd0, irq}, 32'h0);

    // W1C on the same edge that a new press sets edgecap[0]: set wins.
    bus_write(2'd3, 32'h3);
    in_port = 2'b10;
    tick(9);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, "w1c_vs_set", 32'h1);
    check_val("w1c_vs_set_irq", {31'd0, irq}, 32'h1);

    // Release key 0 and reset when its counter has reached 5.
    in_port = 2'b11;
    tick(7);
    reset_n = 1'b0;
    tick();
    check_val("midrst_readdata", readdata, 32'h0);
    check_val("midrst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    bus_read(2'd0, "midrst_data", 32'h3);
    bus_read(2'd2, "midrst_mask", 32'h0);
    bus_read(2'd3, "midrst_edge", 32'h0);
    check_val("midrst_irq2", {31'd0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
